// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader
//
// Avalon-MM burst read master. It fetches a linear region of SDRAM in bursts
// of up to BURST_LEN words into an internal FIFO. The FIFO contents are
// presented as a valid/ready stream with a registered, first-word
// fall-through head.
//
// Optional feature: define SDRAM_READER_LOOP_EN to restart the same transfer
// automatically after every completion. This gives continuous scan-out, and
// only reset stops it.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     one-cycle launch pulse (ignored while busy)
//   base_addr, word_count     byte start address / word total, sampled on start
//   busy, done                transfer in progress / last word left the stream
//   address, burstcount, read Avalon request (held while waitrequest)
//   waitrequest               Avalon stall
//   readdata, readdatavalid   Avalon return data
//   out_data, out_valid       stream output
//   out_ready                 stream backpressure
module sdram_burst_reader #(
  parameter int unsigned WIDTH_ADDR = 32,
  parameter int unsigned WIDTH_DATA = 64,
  parameter int unsigned WIDTH_BE   = 8,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH_ADDR-1:0] base_addr,
  input  logic [23:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH_ADDR-1:0] address,
  output logic [7:0]            burstcount,
  output logic                  read,
  input  logic                  waitrequest,
  input  logic [WIDTH_DATA-1:0] readdata,
  input  logic                  readdatavalid,
  output logic [WIDTH_DATA-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StCheck, StReq, StFinish} state_e;

  state_e                state_q, state_d;
  logic [WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [23:0]           req_left_q, req_left_d;
  logic [23:0]           out_left_q, out_left_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [WIDTH_ADDR-1:0] address_q, address_d;
  logic [7:0]            burstcount_q, burstcount_d;
  logic                  read_q, read_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef SDRAM_READER_LOOP_EN
  logic [WIDTH_ADDR-1:0] loop_base_q, loop_base_d;
  logic [23:0]           loop_count_q, loop_count_d;
`endif

  // FIFO storage and a registered head word
  logic [WIDTH_DATA-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         level_q, level_d;
  logic [WIDTH_DATA-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  push;
  logic                  pop;
  logic                  accept;
  logic [7:0]            blen;
  logic [CW-1:0]         credit_free;
  logic                  credit_ok;

  // Beats with nothing outstanding are protocol errors (or stale after reset)
  assign push   = readdatavalid && (outstanding_q != '0);
  assign pop    = out_valid_q && out_ready;
  assign accept = (state_q == StReq) && read_q && !waitrequest;

  assign blen = (req_left_q >= 24'(BURST_LEN)) ? 8'(BURST_LEN) : req_left_q[7:0];

  // Words already in the FIFO plus words still in flight must leave room for
  // the whole next burst, so readdatavalid can never overflow the FIFO.
  assign credit_free = CW'(FIFO_DEPTH) - level_q - outstanding_q;
  assign credit_ok   = (32'(credit_free) >= 32'(blen));

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    level_d     = level_q + CW'(push) - CW'(pop);
    out_valid_d = (level_d != '0);
    out_data_d  = out_data_q;
    if (push && ((level_q - CW'(pop)) == '0)) begin
      // Word being written becomes the head: bypass the memory.
      out_data_d = readdata;
    end else if (level_d != '0) begin
      out_data_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= readdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-word tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    outstanding_d = outstanding_q;
    if (push) begin
      outstanding_d = outstanding_d - CW'(1);
    end
    if (accept) begin
      outstanding_d = outstanding_d + CW'(burstcount_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    req_left_d   = req_left_q;
    out_left_d   = out_left_q - 24'(pop);
    address_d    = address_q;
    burstcount_d = burstcount_q;
    read_d       = read_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef SDRAM_READER_LOOP_EN
    loop_base_d  = loop_base_q;
    loop_count_d = loop_count_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d     = base_addr;
          req_left_d = word_count;
          out_left_d = word_count;
          busy_d     = 1'b1;
          state_d    = (word_count == '0) ? StFinish : StCheck;
`ifdef SDRAM_READER_LOOP_EN
          loop_base_d  = base_addr;
          loop_count_d = word_count;
`endif
        end
      end

      StCheck: begin
        if (credit_ok) begin
          read_d       = 1'b1;
          address_d    = addr_q;
          burstcount_d = blen;
          state_d      = StReq;
        end
      end

      StReq: begin
        if (accept) begin
          read_d     = 1'b0;
          req_left_d = req_left_q - 24'(burstcount_q);
          addr_d     = addr_q + (WIDTH_ADDR'(burstcount_q) * WIDTH_ADDR'(WIDTH_BE));
          state_d    = (req_left_d == '0) ? StFinish : StCheck;
        end
      end

      StFinish: begin
        if (out_left_q == '0) begin
          done_d = 1'b1;
`ifdef SDRAM_READER_LOOP_EN
          addr_d     = loop_base_q;
          req_left_d = loop_count_q;
          out_left_d = loop_count_q;
          state_d    = (loop_count_q == '0) ? StFinish : StCheck;
`else
          busy_d  = 1'b0;
          state_d = StIdle;
`endif
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      req_left_q    <= '0;
      out_left_q    <= '0;
      outstanding_q <= '0;
      address_q     <= '0;
      burstcount_q  <= '0;
      read_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
`ifdef SDRAM_READER_LOOP_EN
      loop_base_q   <= '0;
      loop_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      req_left_q    <= req_left_d;
      out_left_q    <= out_left_d;
      outstanding_q <= outstanding_d;
      address_q     <= address_d;
      burstcount_q  <= burstcount_d;
      read_q        <= read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
`ifdef SDRAM_READER_LOOP_EN
      loop_base_q   <= loop_base_d;
      loop_count_q  <= loop_count_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign address    = address_q;
  assign burstcount = burstcount_q;
  assign read       = read_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

endmodule

// File: doc/sdram_burst_reader.md
Name: sdram_burst_reader

Overview:
- Avalon-MM burst read master; drives the read-master side of the SDRAM port (address, burstcount, read, waitrequest, readdata, readdatavalid).
- Fetches a linear region (for example one frame buffer) from SDRAM in bursts into an internal FIFO.
- Presents the fetched words as a valid/ready stream to downstream video logic.
- Counterpart to the frame writers that fill the SDRAM through the write-master port.

Parameters:
- WIDTH_ADDR, 32, Avalon byte-address width
- WIDTH_DATA, 64, data word width
- WIDTH_BE, 8, bytes per word (WIDTH_DATA/8)
- BURST_LEN, 16, maximum words per burst (1..128, fits in burstcount[7:0])
- FIFO_DEPTH, 64, output FIFO depth in words (power of 2, >= 2*BURST_LEN)

Ports:
- clk, input, 1, single clock for all logic
- reset_n, input, 1, asynchronous active-low reset
- start, input, 1, one-cycle pulse; launches a transfer when idle
- base_addr, input, WIDTH_ADDR, byte start address, sampled on start; WIDTH_BE-aligned
- word_count, input, 24, total words to read, sampled on start
- busy, output, 1, high from accepted start until done
- done, output, 1, one-cycle pulse when the last word leaves the stream port
- address, output, WIDTH_ADDR, Avalon burst start address
- burstcount, output, 8, Avalon burst length in words
- read, output, 1, Avalon read request
- waitrequest, input, 1, Avalon slave stall
- readdata, input, WIDTH_DATA, Avalon return data
- readdatavalid, input, 1, Avalon return-data strobe
- out_data, output, WIDTH_DATA, stream data
- out_valid, output, 1, stream valid
- out_ready, input, 1, stream ready

Behaviour:
- Reset values: address=0, burstcount=0, read=0, busy=0, done=0, out_valid=0. FIFO is empty and all counters are 0.
- FSM states: IDLE, CHECK, REQ, FINISH.
- IDLE: start=1 latches base_addr into addr_r, word_count into req_left and out_left, and sets busy=1.
  - word_count=0: go to FINISH and issue no reads.
  - Otherwise: go to CHECK.
  - start while busy=1 is ignored.
- CHECK: blen = min(BURST_LEN, req_left). Credit rule: free = FIFO_DEPTH - fifo_level - outstanding.
  - free >= blen: go to REQ, driving read=1, address=addr_r, burstcount=blen.
  - Otherwise: stay in CHECK.
- REQ: read, address and burstcount are held stable while waitrequest=1.
  - Acceptance occurs on the first cycle with read=1 and waitrequest=0. On that cycle: read drops next cycle; outstanding += blen; req_left -= blen; addr_r += blen*WIDTH_BE.
  - Then go to CHECK if req_left != 0, else to FINISH.
  - Minimum gap between bursts is one cycle (REQ->CHECK->REQ).
- Return path:
  - Each readdatavalid=1 writes readdata into the FIFO and decrements outstanding.
  - If acceptance and readdatavalid occur in the same cycle, outstanding changes by blen-1.
  - The credit rule guarantees no FIFO overflow. readdatavalid arriving with outstanding=0 is a protocol error; the data is dropped.
- Stream:
  - out_valid = FIFO not empty; out_data = FIFO head; registered output, first-word fall-through.
  - A word pops when out_valid and out_ready are both 1; out_left decrements.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- FINISH: waits for out_left=0, then asserts done for one cycle, clears busy, and returns to IDLE.
- Latency: start to first read is 2 cycles. readdatavalid to out_valid is 1 cycle when the FIFO is empty.
- Address arithmetic wraps modulo 2^WIDTH_ADDR with no error flag.
- Simultaneous FIFO push and pop on the same cycle are both honoured; the level is unchanged.
- Reset asserted mid-transfer aborts everything immediately. After reset release, stale readdatavalid beats are not counted; the slave must be idle at reset.

Optional Feature:
- Macro: SDRAM_READER_LOOP_EN.
- Defined: when out_left reaches 0 in FINISH, done pulses and the transfer restarts automatically from the latched base_addr with the latched word_count. busy stays 1; only reset stops the loop. This supports continuous frame-buffer scan-out.
- Undefined: single-shot behaviour as described above.

Test Plan:
- base_addr=0x1000, word_count=40, BURST_LEN=16, waitrequest=0, out_ready=1 -> three bursts at 0x1000/16, 0x1080/16, 0x1100/8; 40 words out in order; one done pulse; busy low afterwards.
- waitrequest held high 5 cycles on the 2nd burst -> address=0x1080 and burstcount=16 stable all 5 cycles; exactly one burst accepted.
- out_ready=0 for the whole run, word_count=200, FIFO_DEPTH=64 -> outstanding+level never exceeds 64; reads stall; no data lost once out_ready=1.
- word_count=0 -> no read asserted; done pulse 2 cycles after start.
- reset_n pulsed low mid-burst -> all outputs return to reset values within the same cycle; a new start afterwards completes normally.
- SDRAM_READER_LOOP_EN defined, word_count=20 -> done pulses every 20 output words; addresses restart at base_addr; busy stays 1.
